sram_port_ctrl: RTL and testbench

//  Single-port controller for the 16-bit async SRAM behind the Z80 controller's ramreq/ramwr/a/dout/sdata

---
 rtl/sram_pkg.sv | 27 ++
 rtl/sram_rr_arb.sv | 30 +++
 rtl/sram_port_ctrl.sv | 200 ++++++++++++++++++++
 tb/tb_sram_port_ctrl.sv | 315 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sram_pkg.sv
// -----------------------------------------------------------------------------
// sram_pkg
// Shared types and constants for the SRAM port controller.
//   state_t  : access sequencer states (IDLE -> SETUP -> STROBE -> HOLD)
//   client_t : bus clients that can own an access (CPU, video)
//   STROBE_MIN / STROBE_MAX : legal range of the strobe-length parameter
// -----------------------------------------------------------------------------
package sram_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETUP  = 2'd1,
        ST_STROBE = 2'd2,
        ST_HOLD   = 2'd3
    } state_t;

    typedef enum logic {
        CLI_CPU = 1'b0,
        CLI_VID = 1'b1
    } client_t;

    localparam int STROBE_MIN = 1;
    localparam int STROBE_MAX = 4;
    // Strobe counter runs 0..STROBE_MAX-1.
    localparam int STROBE_CW  = $clog2(STROBE_MAX);

endpackage

// File: rtl/sram_rr_arb.sv
// -----------------------------------------------------------------------------
// sram_rr_arb
// Two-way round-robin arbiter, purely combinational.
// Ports:
//   req_i        [1:0] request vector, bit 0 = CPU, bit 1 = video
//   last_grant_i       client that won the previous grant (client_t encoding)
//   gnt_o        [1:0] one-hot grant, same bit order as req_i; 0 if no request
// On a tie the client that did not win last time is granted.
// -----------------------------------------------------------------------------
module sram_rr_arb
    import sram_pkg::*;
(
    input  logic [1:0] req_i,
    input  logic       last_grant_i,
    output logic [1:0] gnt_o
);

    always_comb begin
        // NOTE: every output gets a default before any branch, so no path
        // leaves it unassigned and no latch is inferred.
        gnt_o = 2'b00;
        case (req_i)
            2'b01:   gnt_o = 2'b01;
            2'b10:   gnt_o = 2'b10;
            2'b11:   gnt_o = (last_grant_i == CLI_VID) ? 2'b01 : 2'b10;
            default: gnt_o = 2'b00;
        endcase
    end

endmodule

// File: rtl/sram_port_ctrl.sv
// -----------------------------------------------------------------------------
// sram_port_ctrl
// Single-port controller for a 16-bit asynchronous SRAM shared by the Z80
// byte interface and a video word-read client.
// Ports:
//   mclk, reset                  clock, synchronous active-high reset
//   cpu_req/cpu_wr/cpu_a/cpu_dout Z80 request, direction, byte address, write byte
//   cpu_wait                     high while the CPU access is pending or in flight
//   rd_data                      last word read from the SRAM (held between reads)
//   vid_req/vid_a                video word-read request (level) and word address
//   vid_ack                      one-cycle pulse, rd_data valid for video
//   sram_*                       SRAM pins; all strobes and d_oe are registered
// Each access runs IDLE -> SETUP -> STROBE (STROBE cycles) -> HOLD -> IDLE.
// Arbitration happens only in IDLE.
// -----------------------------------------------------------------------------
module sram_port_ctrl
    import sram_pkg::*;
#(
    parameter int AW       = 18,
    parameter int STROBE   = 1,
    parameter int CPU_PAGE = 0
) (
    input  logic          mclk,
    input  logic          reset,
    input  logic          cpu_req,
    input  logic          cpu_wr,
    input  logic [15:0]   cpu_a,
    input  logic [7:0]    cpu_dout,
    output logic          cpu_wait,
    output logic [15:0]   rd_data,
    input  logic          vid_req,
    input  logic [AW-1:0] vid_a,
    output logic          vid_ack,
    output logic [AW-1:0] sram_a,
    input  logic [15:0]   sram_d_i,
    output logic [15:0]   sram_d_o,
    output logic          sram_d_oe,
    output logic          sram_oe_n,
    output logic          sram_we_n,
    output logic          sram_ub_n,
    output logic          sram_lb_n
);

    // Out-of-range strobe lengths are clamped to the legal range.
    localparam int STROBE_EFF = (STROBE < STROBE_MIN) ? STROBE_MIN :
                                (STROBE > STROBE_MAX) ? STROBE_MAX : STROBE;
    localparam logic [STROBE_CW-1:0] STROBE_LAST = STROBE_CW'(STROBE_EFF - 1);
    localparam int PW = AW - 15;
    localparam logic [PW-1:0] PAGE_BITS = PW'(CPU_PAGE);

    state_t                state_q, state_d;
    logic [STROBE_CW-1:0]  cnt_q, cnt_d;
    client_t               client_q, client_d;
    client_t               last_grant_q, last_grant_d;
    logic                  wr_q, wr_d;
    logic [AW-1:0]         addr_q, addr_d;
    logic [7:0]            wdata_q, wdata_d;
    logic [15:0]           lat_a_q, lat_a_d;
    logic                  lat_wr_q, lat_wr_d;
    logic                  cpu_done_q, cpu_done_d;
    logic [15:0]           rd_data_q, rd_data_d;
    logic                  vid_ack_q, vid_ack_d;
    logic                  oe_n_q, oe_n_d, we_n_q, we_n_d;
    logic                  ub_n_q, ub_n_d, lb_n_q, lb_n_d;
    logic                  d_oe_q, d_oe_d;
    logic                  strobe_next;
    logic                  cpu_done, cpu_pend;
    logic [1:0]            gnt;

    // A finished CPU access stays "done" only while the very same request is
    // still presented; any change of address/direction or a dropped request
    // makes it a new access.
    assign cpu_done = cpu_done_q && cpu_req && (cpu_a == lat_a_q) && (cpu_wr == lat_wr_q);
    assign cpu_pend = cpu_req && !cpu_done;
    assign cpu_wait = cpu_pend;

    sram_rr_arb u_arb (
        .req_i        ({vid_req, cpu_pend}),
        .last_grant_i (last_grant_q),
        .gnt_o        (gnt)
    );

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        client_d     = client_q;
        last_grant_d = last_grant_q;
        wr_d         = wr_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        lat_a_d      = lat_a_q;
        lat_wr_d     = lat_wr_q;
        cpu_done_d   = cpu_done;
        rd_data_d    = rd_data_q;
        vid_ack_d    = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (state_q == ST_IDLE && gnt[0]) begin
                    client_d     = CLI_CPU;
                    last_grant_d = CLI_CPU;
                    wr_d         = cpu_wr;
                    addr_d       = {PAGE_BITS, cpu_a[15:1]};
                    wdata_d      = cpu_dout;
                    lat_a_d      = cpu_a;
                    lat_wr_d     = cpu_wr;
                    cpu_done_d   = 1'b0;
                    state_d      = ST_SETUP;
                end else if (gnt[1]) begin
                    client_d     = CLI_VID;
                    last_grant_d = CLI_VID;
                    wr_d         = 1'b0;
                    addr_d       = vid_a;
                    state_d      = ST_SETUP;
                end
            end
            ST_SETUP: begin
                cnt_d   = '0;
                state_d = ST_STROBE;
            end
            ST_STROBE: begin
                if (cnt_q == STROBE_LAST) begin
                    state_d = ST_HOLD;
                    if (!wr_q) rd_data_d = sram_d_i;
                    // Completion is registered so it is visible during HOLD.
                    if (client_q == CLI_CPU) cpu_done_d = 1'b1;
                    else                     vid_ack_d  = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_HOLD:  state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase

        // Pin strobes are decoded from the *next* state and registered, so the
        // pins change cleanly on the clock edge with no decode glitches.
        strobe_next = (state_d == ST_STROBE);
        oe_n_d = !(strobe_next && !wr_d);
        we_n_d = !(strobe_next && wr_d);
        ub_n_d = !(strobe_next && (!wr_d || lat_a_d[0]));
        lb_n_d = !(strobe_next && (!wr_d || !lat_a_d[0]));
        d_oe_d = wr_d && (state_d != ST_IDLE);
    end

    always_ff @(posedge mclk) begin
        // NOTE: reset is synchronous; it only takes effect on a clock edge and
        // aborts any access in flight without completing it.
        if (reset) begin
            state_q      <= ST_IDLE;
            cnt_q        <= '0;
            client_q     <= CLI_CPU;
            last_grant_q <= CLI_VID;
            wr_q         <= 1'b0;
            addr_q       <= '0;
            wdata_q      <= '0;
            lat_a_q      <= '0;
            lat_wr_q     <= 1'b0;
            cpu_done_q   <= 1'b0;
            rd_data_q    <= '0;
            vid_ack_q    <= 1'b0;
            oe_n_q       <= 1'b1;
            we_n_q       <= 1'b1;
            ub_n_q       <= 1'b1;
            lb_n_q       <= 1'b1;
            d_oe_q       <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register samples the
            // pre-edge values, independent of statement order.
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            client_q     <= client_d;
            last_grant_q <= last_grant_d;
            wr_q         <= wr_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            lat_a_q      <= lat_a_d;
            lat_wr_q     <= lat_wr_d;
            cpu_done_q   <= cpu_done_d;
            rd_data_q    <= rd_data_d;
            vid_ack_q    <= vid_ack_d;
            oe_n_q       <= oe_n_d;
            we_n_q       <= we_n_d;
            ub_n_q       <= ub_n_d;
            lb_n_q       <= lb_n_d;
            d_oe_q       <= d_oe_d;
        end
    end

    assign rd_data   = rd_data_q;
    assign vid_ack   = vid_ack_q;
    assign sram_a    = addr_q;
    assign sram_d_o  = {wdata_q, wdata_q};
    assign sram_d_oe = d_oe_q;
    assign sram_oe_n = oe_n_q;
    assign sram_we_n = we_n_q;
    assign sram_ub_n = ub_n_q;
    assign sram_lb_n = lb_n_q;

endmodule

// File: tb/tb_sram_port_ctrl.sv
// -----------------------------------------------------------------------------
// tb_sram_port_ctrl
// Bench for sram_port_ctrl. Instance u_dut uses default parameters and sits on
// a behavioural async SRAM; instance u_dut3 uses STROBE=3 with a constant data
// bus. Expected read data comes from a transaction-level reference memory that
// the bench updates when it issues CPU writes.
// -----------------------------------------------------------------------------
module tb_sram_port_ctrl;
    localparam int AW = 18;

    logic mclk = 1'b0;
    always #5 mclk = ~mclk;

    // ---- default instance ----
    logic          reset, cpu_req, cpu_wr, cpu_wait, vid_req, vid_ack;
    logic [15:0]   cpu_a, rd_data, sram_d_i, sram_d_o;
    logic [7:0]    cpu_dout;
    logic [AW-1:0] vid_a, sram_a;
    logic          sram_d_oe, sram_oe_n, sram_we_n, sram_ub_n, sram_lb_n;

    sram_port_ctrl u_dut (
        .mclk(mclk), .reset(reset), .cpu_req(cpu_req), .cpu_wr(cpu_wr),
        .cpu_a(cpu_a), .cpu_dout(cpu_dout), .cpu_wait(cpu_wait), .rd_data(rd_data),
        .vid_req(vid_req), .vid_a(vid_a), .vid_ack(vid_ack), .sram_a(sram_a),
        .sram_d_i(sram_d_i), .sram_d_o(sram_d_o), .sram_d_oe(sram_d_oe),
        .sram_oe_n(sram_oe_n), .sram_we_n(sram_we_n), .sram_ub_n(sram_ub_n),
        .sram_lb_n(sram_lb_n)
    );

    // ---- STROBE=3 instance ----
    logic          reset_b, cpu_req_b, cpu_wr_b, cpu_wait_b, vid_ack_b;
    logic [15:0]   cpu_a_b, rd_data_b, sram_d_o_b;
    logic [7:0]    cpu_dout_b;
    logic [AW-1:0] sram_a_b;
    logic          sram_d_oe_b, sram_oe_n_b, sram_we_n_b, sram_ub_n_b, sram_lb_n_b;

    sram_port_ctrl #(.AW(AW), .STROBE(3), .CPU_PAGE(0)) u_dut3 (
        .mclk(mclk), .reset(reset_b), .cpu_req(cpu_req_b), .cpu_wr(cpu_wr_b),
        .cpu_a(cpu_a_b), .cpu_dout(cpu_dout_b), .cpu_wait(cpu_wait_b), .rd_data(rd_data_b),
        .vid_req(1'b0), .vid_a('0), .vid_ack(vid_ack_b), .sram_a(sram_a_b),
        .sram_d_i(16'hC0DE), .sram_d_o(sram_d_o_b), .sram_d_oe(sram_d_oe_b),
        .sram_oe_n(sram_oe_n_b), .sram_we_n(sram_we_n_b), .sram_ub_n(sram_ub_n_b),
        .sram_lb_n(sram_lb_n_b)
    );

    // ---- behavioural SRAM on the pins, plus transaction-level reference ----
    bit [15:0] sram_mem [0:(1<<AW)-1];
    bit [15:0] ref_mem  [0:(1<<AW)-1];

    assign sram_d_i = sram_oe_n ? 16'hDEAD : sram_mem[sram_a];

    always @(posedge mclk) begin
        if (!sram_we_n && sram_d_oe) begin
            if (!sram_ub_n) sram_mem[sram_a][15:8] <= sram_d_o[15:8];
            if (!sram_lb_n) sram_mem[sram_a][7:0]  <= sram_d_o[7:0];
        end
    end

    int oe_cycles = 0, bus_clash = 0, oe_cycles_b = 0, acc_b = 0;
    logic oe_prev_b = 1'b1;
    always @(negedge mclk) begin
        if (!sram_oe_n) oe_cycles++;
        if (!sram_oe_n && sram_d_oe) bus_clash++;
        if (!sram_oe_n_b) oe_cycles_b++;
        if (!sram_oe_n_b && oe_prev_b) acc_b++;
        oe_prev_b = sram_oe_n_b;
    end

    // ---- checking ----
    int n_cmp = 0, n_err = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge mclk);
    endtask

    function automatic logic [AW-1:0] cpu_word(input logic [15:0] a);
        return {3'b000, a[15:1]};
    endfunction

    // Lone CPU access; exp_lat < 0 skips the latency comparison.
    task automatic cpu_op(input logic wr, input logic [15:0] a, input logic [7:0] d,
                          input int exp_lat, input string tag);
        int cyc = 0;
        logic [AW-1:0] wa;
        wa = cpu_word(a);
        cpu_req = 1'b1; cpu_wr = wr; cpu_a = a; cpu_dout = d;
        #1;
        while (cpu_wait && cyc < 20) begin tick(); cyc++; end
        check({tag, "_done"}, cpu_wait, 1'b0);
        if (exp_lat >= 0) check({tag, "_lat"}, cyc, exp_lat);
        if (wr) begin
            if (a[0]) ref_mem[wa][15:8] = d;
            else      ref_mem[wa][7:0]  = d;
        end else begin
            check({tag, "_rd"}, rd_data, ref_mem[wa]);
        end
        cpu_req = 1'b0;
        tick();
    endtask

    task automatic vid_op(input logic [AW-1:0] va, input int exp_lat, input string tag);
        int cyc = 0;
        vid_req = 1'b1; vid_a = va;
        #1;
        while (!vid_ack && cyc < 20) begin tick(); cyc++; end
        check({tag, "_ack"}, vid_ack, 1'b1);
        if (exp_lat >= 0) check({tag, "_lat"}, cyc, exp_lat);
        check({tag, "_rd"}, rd_data, ref_mem[va]);
        vid_req = 1'b0;
        tick();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    bit order[$];   // completion order, 1 = video

    initial begin
        int c_done, v_done, seen;
        logic [15:0] ra;
        logic [AW-1:0] rv;

        cpu_req = 0; cpu_wr = 0; cpu_a = 0; cpu_dout = 0; vid_req = 0; vid_a = 0;
        cpu_req_b = 0; cpu_wr_b = 0; cpu_a_b = 0; cpu_dout_b = 0;
        reset = 1; reset_b = 1;
        for (int w = 0; w < 16; w++) begin
            sram_mem[w] = 16'($urandom); ref_mem[w] = sram_mem[w];
        end
        sram_mem[18'h02000] = 16'h12AB;        ref_mem[18'h02000] = 16'h12AB;
        sram_mem[18'h04000] = 16'h9C00;        ref_mem[18'h04000] = 16'h9C00;
        sram_mem[18'h3FFFF] = 16'($urandom);   ref_mem[18'h3FFFF] = sram_mem[18'h3FFFF];
        repeat (3) tick();
        reset = 0; reset_b = 0;
        tick();

        // Reset state
        check("rst_oe_n", sram_oe_n, 1'b1);
        check("rst_we_n", sram_we_n, 1'b1);
        check("rst_lanes", {sram_ub_n, sram_lb_n}, 2'b11);
        check("rst_d_oe", sram_d_oe, 1'b0);
        check("rst_sram_a", sram_a, 0);
        check("rst_rd_data", rd_data, 0);
        check("rst_vid_ack", vid_ack, 1'b0);
        check("rst_cpu_wait", cpu_wait, 1'b0);

        // CPU read of 0x4001 -> word 0x2000
        oe_cycles = 0;
        cpu_op(1'b0, 16'h4001, 8'h00, 3, "cpu_rd4001");
        check("cpu_rd_oe_cycles", oe_cycles, 1);
        check("cpu_rd_word", rd_data, 16'h12AB);
        check("cpu_rd_addr", sram_a, 18'h02000);

        // CPU write 0x8000 <- 0x5A, stepped cycle by cycle
        cpu_req = 1; cpu_wr = 1; cpu_a = 16'h8000; cpu_dout = 8'h5A;
        #1;
        check("wr_c0_d_oe", sram_d_oe, 1'b0);
        tick();
        check("wr_setup_d_oe", sram_d_oe, 1'b1);
        check("wr_setup_we_n", sram_we_n, 1'b1);
        check("wr_setup_addr", sram_a, 18'h04000);
        tick();
        check("wr_strobe_pins", {sram_we_n, sram_oe_n, sram_ub_n, sram_lb_n}, 4'b0110);
        check("wr_strobe_data", sram_d_o, 16'h5A5A);
        check("wr_strobe_d_oe", sram_d_oe, 1'b1);
        tick();
        check("wr_hold_we_n", sram_we_n, 1'b1);
        check("wr_hold_d_oe", sram_d_oe, 1'b1);
        check("wr_hold_wait", cpu_wait, 1'b0);
        ref_mem[18'h04000][7:0] = 8'h5A;
        cpu_req = 0;
        tick();
        check("wr_idle_d_oe", sram_d_oe, 1'b0);
        cpu_op(1'b0, 16'h8000, 8'h00, 3, "wr_readback");
        check("wr_rb_word", rd_data, 16'h9C5A);

        // Simultaneous CPU and video after reset: CPU first, video ack at cycle 7
        reset = 1; tick(); reset = 0; tick();
        cpu_req = 1; cpu_wr = 0; cpu_a = 16'h0010; vid_req = 1; vid_a = 18'h3FFFF;
        c_done = -1; v_done = -1;
        for (int k = 0; k < 12; k++) begin
            #1;
            if (c_done < 0 && !cpu_wait) begin
                c_done = k; check("tie_cpu_rd", rd_data, ref_mem[18'h00008]); cpu_req = 0;
            end
            if (v_done < 0 && vid_ack) begin
                v_done = k; check("tie_vid_rd", rd_data, ref_mem[18'h3FFFF]); vid_req = 0;
            end
            tick();
        end
        check("tie_cpu_cycle", c_done, 3);
        check("tie_vid_cycle", v_done, 7);

        // Video request withdrawn before it is granted: no video access
        cpu_req = 1; cpu_wr = 0; cpu_a = 16'h0004; vid_req = 1; vid_a = 18'h5;
        oe_cycles = 0; seen = 0;
        tick();
        vid_req = 0;
        for (int k = 1; k < 10; k++) begin
            #1;
            if (vid_ack) seen = 1;
            if (cpu_req && !cpu_wait) cpu_req = 0;
            tick();
        end
        check("vid_drop_no_ack", seen, 0);
        check("vid_drop_one_access", oe_cycles, 1);

        // Round robin: last grant is CPU, then both stream continuously
        cpu_op(1'b0, 16'h0002, 8'h00, 3, "rr_pre");
        fork
            begin : vid_stream
                logic [AW-1:0] va;
                int cyc;
                vid_req = 1;
                for (int i = 0; i < 4; i++) begin
                    va = AW'($urandom_range(0, 15)); vid_a = va; cyc = 0;
                    do begin tick(); #1; cyc++; end while (!vid_ack && cyc < 16);
                    check("rr_vid_ack", vid_ack, 1'b1);
                    check("rr_vid_rd", rd_data, ref_mem[va]);
                    order.push_back(1'b1);
                end
                vid_req = 0;
            end
            begin : cpu_stream
                logic [15:0] a;
                logic [7:0] d;
                logic wr;
                int cyc;
                for (int i = 0; i < 4; i++) begin
                    a = 16'($urandom_range(0, 31)); d = 8'($urandom); wr = 1'($urandom);
                    cpu_req = 1; cpu_wr = wr; cpu_a = a; cpu_dout = d; cyc = 0;
                    #1;
                    while (cpu_wait && cyc < 16) begin tick(); #1; cyc++; end
                    check("rr_cpu_wait_bound", cyc <= 8, 1'b1);
                    if (wr) begin
                        if (a[0]) ref_mem[cpu_word(a)][15:8] = d;
                        else      ref_mem[cpu_word(a)][7:0]  = d;
                    end else begin
                        check("rr_cpu_rd", rd_data, ref_mem[cpu_word(a)]);
                    end
                    order.push_back(1'b0);
                    cpu_req = 0;
                    tick();
                end
            end
        join
        repeat (3) tick();
        check("rr_count", order.size(), 8);
        if (order.size() == 8) begin
            check("rr_first_vid", order[0], 1'b1);
            for (int i = 1; i < 8; i++) check("rr_alternate", order[i], !order[i-1]);
        end

        // Randomized isolated accesses against the reference memory
        for (int i = 0; i < 24; i++) begin
            case ($urandom_range(0, 2))
                0: begin ra = 16'($urandom_range(0, 31));
                         cpu_op(1'b0, ra, 8'h00, 3, "rnd_cpu_rd"); end
                1: begin ra = 16'($urandom_range(0, 31));
                         cpu_op(1'b1, ra, 8'($urandom), 3, "rnd_cpu_wr"); end
                default: begin rv = AW'($urandom_range(0, 15));
                         vid_op(rv, 3, "rnd_vid"); end
            endcase
            repeat ($urandom_range(0, 2)) tick();
        end
        check("no_bus_clash", bus_clash, 0);

        // STROBE=3: held request with unchanged address is served once
        cpu_req_b = 1; cpu_wr_b = 0; cpu_a_b = 16'h0010; acc_b = 0; oe_cycles_b = 0;
        for (int k = 0; k < 10; k++) begin
            #1;
            check("s3_wait_profile", cpu_wait_b, (k < 5) ? 1'b1 : 1'b0);
            tick();
        end
        cpu_req_b = 0;
        check("s3_one_access", acc_b, 1);
        check("s3_oe_cycles", oe_cycles_b, 3);
        check("s3_rd_data", rd_data_b, 16'hC0DE);
        tick();

        // STROBE=3: reset during STROBE of a write aborts it
        cpu_req_b = 1; cpu_wr_b = 1; cpu_a_b = 16'h0003; cpu_dout_b = 8'h77;
        tick(); tick();
        #1;
        check("s3_wr_strobe", {sram_we_n_b, sram_ub_n_b, sram_lb_n_b}, 3'b001);
        reset_b = 1;
        tick();
        #1;
        check("s3_rst_we_n", sram_we_n_b, 1'b1);
        check("s3_rst_d_oe", sram_d_oe_b, 1'b0);
        check("s3_rst_lanes", {sram_ub_n_b, sram_lb_n_b}, 2'b11);
        check("s3_rst_no_done", cpu_wait_b, 1'b1);
        check("s3_rst_no_ack", vid_ack_b, 1'b0);
        check("s3_rst_rd_data", rd_data_b, 16'h0000);
        cpu_req_b = 0;
        tick();
        reset_b = 0;
        tick();
        check("s3_idle_pins", {sram_we_n_b, sram_oe_n_b, sram_d_oe_b}, 3'b110);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
